// File: rtl/prog_run_seq_if.sv
// rtl/prog_run_seq_if.sv - load and dump stream bundle for the program-run sequencer
interface prog_run_seq_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;

    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/prog_run_seq.sv
// rtl/prog_run_seq.sv - loads IMEM/DMEM from a stream, runs the CPU for N cycles, dumps DMEM
module prog_run_seq #(
    parameter int CNT_W  = 32,
    parameter int ILEN_W = 10,
    parameter int DLEN_W = 11
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic [ILEN_W-1:0] i_len,
    input  logic [DLEN_W-1:0] d_len,
    input  logic [CNT_W-1:0]  run_cycles,
    input  logic [DLEN_W-1:0] dump_len,
    prog_run_seq_if.slave     bus,
    output logic [31:0]       addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [31:0]       wdata_ext,
    output logic [31:0]       addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [31:0]       wdata_ext_2,
    input  logic [31:0]       rdata_ext_2,
    output logic              cpu_arst_n,
    output logic              cpu_enable,
    output logic              busy,
    output logic              done
);
    typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, RUN, DUMP_RD, DUMP_WAIT, DUMP_OUT} state_t;

    state_t            state_q, state_d;
    logic [DLEN_W-1:0] il_q, il_d, dl_q, dl_d, dump_q, dump_d;
    logic [CNT_W-1:0]  rc_q, rc_d, cyc_q, cyc_d;
    logic [DLEN_W-1:0] idx_q, idx_d, k_q, k_d;
    logic              busy_q, busy_d, done_q, done_d, arstn_q, arstn_d;
    logic [31:0]       mdata_q, mdata_d;
    logic              wen_i_q, wen_i_d, wen_d_q, wen_d_d;
    logic [31:0]       waddr_q, waddr_d, wdata_q, wdata_d;
    logic              s_ready_c, m_valid_c, enable_c, ren2_c;

    function automatic logic [31:0] byte_addr(input logic [DLEN_W-1:0] i);
        return {{(30-DLEN_W){1'b0}}, i, 2'b00};
    endfunction

    always_comb begin
        state_d   = state_q;
        il_d      = il_q;
        dl_d      = dl_q;
        rc_d      = rc_q;
        dump_d    = dump_q;
        cyc_d     = cyc_q;
        idx_d     = idx_q;
        k_d       = k_q;
        busy_d    = busy_q;
        done_d    = done_q;
        arstn_d   = arstn_q;
        mdata_d   = mdata_q;
        wen_i_d   = 1'b0;
        wen_d_d   = 1'b0;
        waddr_d   = '0;
        wdata_d   = '0;
        s_ready_c = 1'b0;
        m_valid_c = 1'b0;
        enable_c  = 1'b0;
        ren2_c    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                il_d    = DLEN_W'(i_len);
                dl_d    = d_len;
                rc_d    = run_cycles;
                dump_d  = dump_len;
                cyc_d   = '0;
                idx_d   = '0;
                k_d     = '0;
                done_d  = 1'b0;
                arstn_d = 1'b0;
                busy_d  = 1'b1;
                if (i_len != '0)                                state_d = LOAD_I;
                else if (d_len != '0)                           state_d = LOAD_D;
                else if (run_cycles != '0 || dump_len != '0) begin
                    state_d = RUN;
                    arstn_d = 1'b1;
                end else begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            // Writes are registered here and issued next cycle, so the last
            // word lands in the first cycle of the following state.
            LOAD_I, LOAD_D: begin
                s_ready_c = 1'b1;
                if (bus.s_valid) begin
                    wen_i_d = (state_q == LOAD_I);
                    wen_d_d = (state_q == LOAD_D);
                    waddr_d = byte_addr(idx_q);
                    wdata_d = bus.s_data;
                    if (idx_q == ((state_q == LOAD_I) ? il_q : dl_q) - DLEN_W'(1)) begin
                        idx_d = '0;
                        if (state_q == LOAD_I && dl_q != '0) begin
                            state_d = LOAD_D;
                        end else begin
                            state_d = RUN;
                            arstn_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + DLEN_W'(1);
                    end
                end
            end
            // RUN is always visited after loading, so the trailing DMEM write
            // can never collide with a dump read on the same port.
            RUN: begin
                enable_c = (rc_q != '0);
                if (rc_q == '0 || cyc_q == rc_q - CNT_W'(1)) begin
                    if (dump_q != '0) begin
                        state_d = DUMP_RD;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cyc_d = cyc_q + CNT_W'(1);
                end
            end
            DUMP_RD: begin
                ren2_c  = 1'b1;
                state_d = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                mdata_d = rdata_ext_2;
                state_d = DUMP_OUT;
            end
            DUMP_OUT: begin
                m_valid_c = 1'b1;
                if (bus.m_ready) begin
                    if (k_q + DLEN_W'(1) == dump_q) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        k_d     = k_q + DLEN_W'(1);
                        state_d = DUMP_RD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            il_q    <= '0;
            dl_q    <= '0;
            rc_q    <= '0;
            dump_q  <= '0;
            cyc_q   <= '0;
            idx_q   <= '0;
            k_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            arstn_q <= 1'b0;
            mdata_q <= '0;
            wen_i_q <= 1'b0;
            wen_d_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            il_q    <= il_d;
            dl_q    <= dl_d;
            rc_q    <= rc_d;
            dump_q  <= dump_d;
            cyc_q   <= cyc_d;
            idx_q   <= idx_d;
            k_q     <= k_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            arstn_q <= arstn_d;
            mdata_q <= mdata_d;
            wen_i_q <= wen_i_d;
            wen_d_q <= wen_d_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.s_ready = s_ready_c;
    assign bus.m_valid = m_valid_c;
    assign bus.m_data  = mdata_q;
    assign addr_ext    = wen_i_q ? waddr_q : '0;
    assign wen_ext     = wen_i_q;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = wen_i_q ? wdata_q : '0;
    assign addr_ext_2  = wen_d_q ? waddr_q : (ren2_c ? byte_addr(k_q) : '0);
    assign wen_ext_2   = wen_d_q;
    assign ren_ext_2   = ren2_c;
    assign wdata_ext_2 = wen_d_q ? wdata_q : '0;
    assign cpu_arst_n  = arstn_q;
    assign cpu_enable  = enable_c;
    assign busy        = busy_q;
    assign done        = done_q;
endmodule

// File: tb/tb_prog_run_seq.sv
// tb/tb_prog_run_seq.sv - directed vector table plus reset/ignore-start sequences for prog_run_seq
module tb_prog_run_seq;
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  i_len = '0;
    logic [10:0] d_len = '0;
    logic [31:0] run_cycles = '0;
    logic [10:0] dump_len = '0;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] rdata_ext_2 = '0;
    logic        cpu_arst_n, cpu_enable, busy, done;

    prog_run_seq_if bus();

    prog_run_seq dut (
        .clk(clk), .arst(arst), .start(start), .i_len(i_len), .d_len(d_len),
        .run_cycles(run_cycles), .dump_len(dump_len), .bus(bus),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         il, dl, rc, dumpl;
        logic [3:0] vpat;
        int         hold, base, rep;
    } vec_t;
    vec_t vecs [5];

    int n_cmp = 0, n_bad = 0, cyc = 0, inv = 0, gen = 0;
    int iw_cyc[$], dw_cyc[$], hs_cyc[$], en_cyc[$];
    logic [31:0] iw_addr[$], iw_data[$], dw_addr[$], dw_data[$], m_words[$];
    logic [31:0] dmem [16];
    int          dmem_gen [16];
    logic        pv, pr;
    logic [31:0] pd;

    function automatic logic [31:0] word(input int base, input int i);
        logic [31:0] prog [4];
        prog = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
        return (base == 0) ? prog[i % 4] : 32'hA + 32'(i);
    endfunction

    // Word 0 defaults to 8: stand-in for the value the CPU program stores there.
    always @(posedge clk)
        if (ren_ext_2)
            rdata_ext_2 <= (dmem_gen[addr_ext_2[5:2]] == gen) ? dmem[addr_ext_2[5:2]]
                         : ((addr_ext_2[5:2] == 4'd0) ? 32'h8 : 32'h0);

    always @(negedge clk) begin
        cyc++;
        if (wen_ext) begin iw_addr.push_back(addr_ext); iw_data.push_back(wdata_ext); iw_cyc.push_back(cyc); end
        if (wen_ext_2) begin
            dw_addr.push_back(addr_ext_2); dw_data.push_back(wdata_ext_2); dw_cyc.push_back(cyc);
            dmem[addr_ext_2[5:2]] = wdata_ext_2; dmem_gen[addr_ext_2[5:2]] = gen;
        end
        if (bus.s_valid && bus.s_ready) hs_cyc.push_back(cyc);
        if (cpu_enable) en_cyc.push_back(cyc);
        if (bus.m_valid && bus.m_ready) m_words.push_back(bus.m_data);
        if ((wen_ext && ren_ext) || (wen_ext_2 && ren_ext_2)) inv++;
        if (!wen_ext && ((addr_ext | wdata_ext) != 0)) inv++;
        if (!wen_ext_2 && (wdata_ext_2 != 0 || (!ren_ext_2 && addr_ext_2 != 0))) inv++;
        if ((bus.s_ready && cpu_arst_n) || (cpu_enable && !cpu_arst_n)) inv++;
        if (pv && !pr && (!bus.m_valid || bus.m_data != pd)) inv++;
        pv = bus.m_valid; pr = bus.m_ready; pd = bus.m_data;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int vi);
        vec_t v;
        int n, sent, dc, guard, hold_left, ib, db, hb, eb, mb;
        logic hs;
        logic [31:0] ew;
        v = vecs[vi];
        n = v.il + v.dl;
        gen++;
        ib = iw_addr.size(); db = dw_addr.size(); hb = hs_cyc.size();
        eb = en_cyc.size();  mb = m_words.size();
        @(posedge clk); #1;
        i_len = 10'(v.il); d_len = 11'(v.dl); run_cycles = v.rc; dump_len = 11'(v.dumpl);
        start = 1'b1;
        hold_left = v.hold;
        bus.m_ready = (hold_left == 0);
        @(posedge clk); #1;
        start = 1'b0;
        check($sformatf("v%0d busy_t1", vi), busy, 1);
        check($sformatf("v%0d done_t1", vi), done, 0);
        check($sformatf("v%0d s_ready_t1", vi), bus.s_ready, 1);
        check($sformatf("v%0d arstn_t1", vi), cpu_arst_n, 0);
        sent = 0; dc = 0; guard = 0;
        while (sent < n && guard < 200) begin
            bus.s_valid = v.vpat[dc % 4];
            bus.s_data  = word(v.base, sent);
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            if (hs) sent++;
            dc++; guard++;
        end
        bus.s_valid = 1'b0; bus.s_data = '0;
        if (v.rep != 0) begin
            i_len = 10'd7; d_len = 11'd5; run_cycles = 32'd50; dump_len = 11'd9; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        guard = 0;
        while (!done && guard < 2000) begin
            bus.m_ready = (hold_left == 0);
            if (bus.m_valid && hold_left > 0) hold_left--;
            @(posedge clk); #1;
            guard++;
        end
        bus.m_ready = 1'b1;
        check($sformatf("v%0d done", vi), done, 1);
        check($sformatf("v%0d busy_end", vi), busy, 0);
        check($sformatf("v%0d arstn_end", vi), cpu_arst_n, 1);
        check($sformatf("v%0d hs_count", vi), hs_cyc.size() - hb, n);
        check($sformatf("v%0d iw_count", vi), iw_addr.size() - ib, v.il);
        check($sformatf("v%0d dw_count", vi), dw_addr.size() - db, v.dl);
        for (int j = 0; j < v.il && ib + j < iw_addr.size() && hb + j < hs_cyc.size(); j++) begin
            check($sformatf("v%0d iw_addr%0d", vi, j), iw_addr[ib+j], 32'(j * 4));
            check($sformatf("v%0d iw_data%0d", vi, j), iw_data[ib+j], word(v.base, j));
            check($sformatf("v%0d iw_lag%0d", vi, j), iw_cyc[ib+j] - hs_cyc[hb+j], 1);
        end
        for (int j = 0; j < v.dl && db + j < dw_addr.size() && hb + v.il + j < hs_cyc.size(); j++) begin
            check($sformatf("v%0d dw_addr%0d", vi, j), dw_addr[db+j], 32'(j * 4));
            check($sformatf("v%0d dw_data%0d", vi, j), dw_data[db+j], word(v.base, v.il + j));
            check($sformatf("v%0d dw_lag%0d", vi, j), dw_cyc[db+j] - hs_cyc[hb+v.il+j], 1);
        end
        check($sformatf("v%0d enable_cycles", vi), en_cyc.size() - eb, v.rc);
        if (v.rc > 0 && en_cyc.size() > eb && hs_cyc.size() >= hb + n) begin
            check($sformatf("v%0d run_start", vi), en_cyc[eb] - hs_cyc[hb+n-1], 1);
            check($sformatf("v%0d enable_contig", vi), en_cyc[en_cyc.size()-1] - en_cyc[eb], v.rc - 1);
        end
        if (v.vpat == 4'hF && hs_cyc.size() >= hb + n)
            check($sformatf("v%0d no_bubble", vi), hs_cyc[hb+n-1] - hs_cyc[hb], n - 1);
        check($sformatf("v%0d dump_count", vi), m_words.size() - mb, v.dumpl);
        for (int k = 0; k < v.dumpl && mb + k < m_words.size(); k++) begin
            ew = (k < v.dl) ? word(v.base, v.il + k) : ((k == 0) ? 32'h8 : 32'h0);
            check($sformatf("v%0d dump%0d", vi, k), m_words[mb+k], ew);
        end
    endtask

    initial begin
        int sent, guard, si, sd, sh;
        logic hs;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.m_ready = 1'b1;
        pv = 1'b0; pr = 1'b0; pd = '0;
        for (int i = 0; i < 16; i++) begin dmem[i] = '0; dmem_gen[i] = -1; end
        vecs[0] = '{4, 0, 12, 1, 4'hF, 0, 0, 0};
        vecs[1] = '{4, 0, 12, 1, 4'h5, 0, 0, 0};
        vecs[2] = '{2, 3, 4,  3, 4'hF, 0, 1, 0};
        vecs[3] = '{0, 3, 2,  3, 4'hF, 5, 1, 0};
        vecs[4] = '{2, 0, 3,  0, 4'hF, 0, 1, 1};

        #2;
        check("reset ctrl", {bus.s_ready, bus.m_valid, busy, done, cpu_arst_n, cpu_enable,
                             wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 0);
        check("reset buses", addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2 | bus.m_data, 0);
        @(posedge clk); #1;
        arst = 1'b0;

        // All-zero start finishes immediately without ever raising busy.
        @(posedge clk); #1;
        start = 1'b1;
        check("zero busy_t0", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("zero done_t1", done, 1);
        check("zero busy_t1", busy, 0);
        @(posedge clk); #1;
        check("zero busy_t2", busy, 0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Asynchronous reset after the first of three DMEM words.
        @(posedge clk); #1;
        i_len = 10'd2; d_len = 11'd3; run_cycles = 32'd5; dump_len = 11'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bus.s_valid = 1'b1;
        sent = 0; guard = 0;
        while (sent < 3 && guard < 50) begin
            bus.s_data = word(1, sent);
            @(negedge clk);
            hs = bus.s_valid && bus.s_ready;
            @(posedge clk); #1;
            if (hs) sent++;
            guard++;
        end
        check("arst pre wen2", wen_ext_2, 1);
        #1 arst = 1'b1;
        #1;
        check("arst ctrl", {bus.s_ready, bus.m_valid, busy, done, cpu_arst_n, cpu_enable,
                            wen_ext, ren_ext, wen_ext_2, ren_ext_2}, 0);
        check("arst buses", addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2 | bus.m_data, 0);
        si = iw_addr.size(); sd = dw_addr.size(); sh = hs_cyc.size();
        @(posedge clk); #1;
        arst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        check("arst no iw", iw_addr.size() - si, 0);
        check("arst no dw", dw_addr.size() - sd, 0);
        check("arst no hs", hs_cyc.size() - sh, 0);
        check("arst idle busy", busy, 0);
        run_vec(2);

        check("invariants", inv, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
